// File: rtl/jtframe_prog_dwnld_if.sv
// Bus bundle for jtframe_prog_dwnld: the ioctl download stream in,
// the SDRAM programming port and PROM strobe out, plus status flags.
// The slave modport is the downloader's view; master is the
// environment (loader + SDRAM controller) view.
interface jtframe_prog_dwnld_if #(
    parameter int AW = 22
);
    logic          downloading;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          ioctl_wr;
    logic [AW-2:0] prog_addr;
    logic [1:0]    prog_ba;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          prog_rdy;
    logic          prom_we;
    logic [AW-1:0] prom_addr;
    logic          dwnld_busy;
    logic          dwnld_done;
    logic          overflow;

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        output prog_addr, prog_ba, prog_data, prog_mask, prog_we,
               prom_we, prom_addr, dwnld_busy, dwnld_done, overflow
    );

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        input  prog_addr, prog_ba, prog_data, prog_mask, prog_we,
               prom_we, prom_addr, dwnld_busy, dwnld_done, overflow
    );
endinterface

// File: rtl/jtframe_prog_dwnld.sv
// jtframe_prog_dwnld: turns the byte-wide ROM download stream into
// SDRAM word writes. Each byte is mapped to one of four banks, placed
// on one lane of a 16-bit word and queued in a small FIFO that drains
// through a we/rdy handshake. The head of the FIFO is kept in output
// registers so prog_* are registered and stable while waiting for rdy.
// Optional feature macro: JTFRAME_DWNLD_PROM_EN -- bytes at or above
// PROM_START bypass the FIFO and become one-cycle prom_we strobes.
module jtframe_prog_dwnld #(
    parameter int            AW         = 22,
    parameter logic [AW-1:0] BA1_START  = 22'h08_0000,
    parameter logic [AW-1:0] BA2_START  = 22'h10_0000,
    parameter logic [AW-1:0] BA3_START  = 22'h18_0000,
    parameter logic [AW-1:0] PROM_START = 22'h20_0000,
    parameter int            SWAB       = 0,
    parameter int            FIFO_AW    = 2
) (
    input logic                  clk,
    input logic                  rst,
    jtframe_prog_dwnld_if.slave  bus
);
    localparam int            DEPTH    = 1 << FIFO_AW;
    localparam int            CW       = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic          SWAB_BIT = (SWAB != 0);

    typedef struct packed {
        logic [AW-2:0] addr;
        logic [1:0]    ba;
        logic [7:0]    data;
        logic [1:0]    mask;
    } entry_t;

    localparam entry_t IDLE_ENTRY = '{addr: {(AW-1){1'b0}}, ba: 2'b00,
                                      data: 8'h00, mask: 2'b11};

    entry_t             mem_q [DEPTH];
    entry_t             head_q, head_d, new_entry_s;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d, remain_s;
    logic               prog_we_q, prog_we_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dl_q;
    logic [1:0]         ba_s;
    logic [AW-1:0]      start_s, rel_s;
    logic               lane_hi_s, is_prom_s, prom_pend_s;
    logic               accept_s, full_s, pop_s, push_s, drop_s, idle_s;

    // Bank decode: highest region whose start does not exceed the address.
    always_comb begin
        ba_s    = 2'd0;
        start_s = {AW{1'b0}};
        if (bus.ioctl_addr >= BA3_START) begin
            ba_s    = 2'd3;
            start_s = BA3_START;
        end else if (bus.ioctl_addr >= BA2_START) begin
            ba_s    = 2'd2;
            start_s = BA2_START;
        end else if (bus.ioctl_addr >= BA1_START) begin
            ba_s    = 2'd1;
            start_s = BA1_START;
        end else begin
            ba_s    = 2'd0;
            start_s = {AW{1'b0}};
        end
        rel_s     = bus.ioctl_addr - start_s;
        lane_hi_s = rel_s[0] ^ SWAB_BIT;
        new_entry_s.addr = rel_s[AW-1:1];
        new_entry_s.ba   = ba_s;
        new_entry_s.data = bus.ioctl_data;
        new_entry_s.mask = lane_hi_s ? 2'b01 : 2'b10;
    end

`ifdef JTFRAME_DWNLD_PROM_EN
    logic          prom_we_q;
    logic [AW-1:0] prom_addr_q;

    assign is_prom_s   = (bus.ioctl_addr >= PROM_START);
    assign prom_pend_s = accept_s & is_prom_s;

    // PROM bypass: one-cycle strobe with the PROM-relative address.
    always_ff @(posedge clk) begin
        if (rst) begin
            prom_we_q   <= 1'b0;
            prom_addr_q <= {AW{1'b0}};
        end else begin
            prom_we_q <= prom_pend_s;
            if (prom_pend_s) begin
                prom_addr_q <= bus.ioctl_addr - PROM_START;
            end
        end
    end

    assign bus.prom_we   = prom_we_q;
    assign bus.prom_addr = prom_addr_q;
`else
    assign is_prom_s     = 1'b0;
    assign prom_pend_s   = 1'b0;
    assign bus.prom_we   = 1'b0;
    // Tied to zero; PROM_START has no effect without the PROM path.
    assign bus.prom_addr = PROM_START & {AW{1'b0}};
`endif

    // FIFO control, head prefetch and status next-state.
    always_comb begin
        accept_s = bus.ioctl_wr & bus.downloading;
        full_s   = (count_q == FULL_CNT);
        pop_s    = prog_we_q & bus.prog_rdy;
        push_s   = accept_s & ~is_prom_s & (~full_s | pop_s);
        drop_s   = accept_s & ~is_prom_s & full_s & ~pop_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
        remain_s = count_q - CW'(pop_s);

        // The new head is either an entry already stored or, when the
        // queue would otherwise be empty, the byte being pushed now.
        if (count_d == {CW{1'b0}}) begin
            head_d = head_q;
        end else if (remain_s == {CW{1'b0}}) begin
            head_d = new_entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        prog_we_d = (count_d != {CW{1'b0}});

        if (bus.downloading & ~dl_q) begin
            overflow_d = drop_s;
        end else begin
            overflow_d = overflow_q | drop_s;
        end

        idle_s = ~bus.downloading & (count_d == {CW{1'b0}}) & ~prom_pend_s;
        busy_d = ~idle_s;
        done_d = idle_s & busy_q;
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= new_entry_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            count_q    <= {CW{1'b0}};
            head_q     <= IDLE_ENTRY;
            prog_we_q  <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            prog_we_q  <= prog_we_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dl_q       <= bus.downloading;
        end
    end

    assign bus.prog_addr  = head_q.addr;
    assign bus.prog_ba    = head_q.ba;
    assign bus.prog_data  = {head_q.data, head_q.data};
    assign bus.prog_mask  = head_q.mask;
    assign bus.prog_we    = prog_we_q;
    assign bus.overflow   = overflow_q;
    assign bus.dwnld_busy = busy_q;
    assign bus.dwnld_done = done_q;
endmodule

// File: tb/tb_jtframe_prog_dwnld.sv
// Self-checking bench for jtframe_prog_dwnld: a table of bank/lane
// vectors plus hand sequences for backpressure, overflow, end of
// download, PROM routing and reset. SDRAM writes are checked against a
// scoreboard queue filled when each byte is driven.
module tb_jtframe_prog_dwnld;
    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        prog_rdy;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [20:0] addr;
        logic [1:0]  ba;
        logic [15:0] data;
        logic [1:0]  mask;
    } exp_t;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [20:0] e_addr;
        logic [1:0]  e_ba;
        logic [1:0]  e_mask;
        logic [1:0]  e_mask_swab;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    jtframe_prog_dwnld_if #(.AW(22)) bus  ();
    jtframe_prog_dwnld_if #(.AW(22)) bus2 ();

    assign bus.downloading  = downloading;
    assign bus.ioctl_addr   = ioctl_addr;
    assign bus.ioctl_data   = ioctl_data;
    assign bus.ioctl_wr     = ioctl_wr;
    assign bus.prog_rdy     = prog_rdy;
    assign bus2.downloading = downloading;
    assign bus2.ioctl_addr  = ioctl_addr;
    assign bus2.ioctl_data  = ioctl_data;
    assign bus2.ioctl_wr    = ioctl_wr;
    assign bus2.prog_rdy    = 1'b1;

    jtframe_prog_dwnld dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jtframe_prog_dwnld #(.SWAB(1)) dut_swab (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare any SDRAM write being accepted this cycle with the scoreboard.
    task automatic monitor();
        exp_t e;
        if (!rst && bus.prog_we && prog_rdy) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h ba %0d data %0h mask %b, expected none",
                         bus.prog_addr, bus.prog_ba, bus.prog_data, bus.prog_mask);
            end else begin
                e = sb_q.pop_front();
                check("prog_entry", {23'd0, bus.prog_addr, bus.prog_ba, bus.prog_data, bus.prog_mask},
                      {23'd0, e.addr, e.ba, e.data, e.mask});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input logic push,
                           input logic [20:0] ea, input logic [1:0] eba, input logic [1:0] em);
        exp_t e;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (push) begin
            e.addr = ea; e.ba = eba; e.data = {d, d}; e.mask = em;
            sb_q.push_back(e);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        int done_cnt;
        vecs[0] = '{22'h00_0000, 8'h11, 21'h00_0000, 2'd0, 2'b10, 2'b01};
        vecs[1] = '{22'h00_0001, 8'h22, 21'h00_0000, 2'd0, 2'b01, 2'b10};
        vecs[2] = '{22'h07_FFFF, 8'h33, 21'h03_FFFF, 2'd0, 2'b01, 2'b10};
        vecs[3] = '{22'h08_0000, 8'h44, 21'h00_0000, 2'd1, 2'b10, 2'b01};
        vecs[4] = '{22'h08_0003, 8'h55, 21'h00_0001, 2'd1, 2'b01, 2'b10};
        vecs[5] = '{22'h0F_FFFE, 8'h66, 21'h03_FFFF, 2'd1, 2'b10, 2'b01};
        vecs[6] = '{22'h10_0003, 8'h77, 21'h00_0001, 2'd2, 2'b01, 2'b10};
        vecs[7] = '{22'h18_0000, 8'h88, 21'h00_0000, 2'd3, 2'b10, 2'b01};
        vecs[8] = '{22'h1F_FFFF, 8'h99, 21'h03_FFFF, 2'd3, 2'b01, 2'b10};

        rst = 1'b1; downloading = 1'b0; ioctl_addr = 22'd0; ioctl_data = 8'd0;
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset state
        check("rst_prog_we", 64'(bus.prog_we), 64'd0);
        check("rst_prom_we", 64'(bus.prom_we), 64'd0);
        check("rst_done", 64'(bus.dwnld_done), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_busy", 64'(bus.dwnld_busy), 64'd0);
        check("rst_outputs", {23'd0, bus.prog_addr, bus.prog_ba, bus.prog_data, bus.prog_mask},
              {23'd0, 21'd0, 2'd0, 16'd0, 2'b11});
        rst = 1'b0;
        tick();

        // Writes while not downloading are ignored
        prog_rdy = 1'b1;
        wr_byte(22'h00_0010, 8'hEE, 1'b0, 21'd0, 2'd0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ignored_no_we", 64'(bus.prog_we), 64'd0);
        end

        // Bank / lane table, rdy high, back to back
        downloading = 1'b1;
        tick();
        check("busy_on_download", 64'(bus.dwnld_busy), 64'd1);
        for (int i = 0; i < 9; i++) begin
            wr_byte(vecs[i].addr, vecs[i].data, 1'b1, vecs[i].e_addr, vecs[i].e_ba, vecs[i].e_mask);
            check("swab_we", 64'(bus2.prog_we), 64'd1);
            check("swab_mask", 64'(bus2.prog_mask), 64'(vecs[i].e_mask_swab));
        end
        drain();

        // Backpressure and overflow with a depth-4 FIFO
        prog_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [21:0] a;
            a = 22'h00_0200 + 22'(i);
            wr_byte(a, 8'hA0 + 8'(i), (i < 4), 21'h00_0100 + 21'(i / 2), 2'd0,
                    (i % 2 == 1) ? 2'b01 : 2'b10);
            if (i == 0) check("latency_we", 64'(bus.prog_we), 64'd1);
        end
        check("overflow_set", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_we", 64'(bus.prog_we), 64'd1);
            check("hold_data", {23'd0, bus.prog_addr, bus.prog_ba, bus.prog_data, bus.prog_mask},
                  {23'd0, 21'h00_0100, 2'd0, 16'hA0A0, 2'b10});
        end
        prog_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("burst_we", 64'(bus.prog_we), 64'd1);
            tick();
        end
        check("burst_end_we", 64'(bus.prog_we), 64'd0);
        check("burst_all_popped", 64'(sb_q.size()), 64'd0);
        downloading = 1'b0;
        tick();
        check("overflow_sticky", 64'(bus.overflow), 64'd1);
        tick();
        downloading = 1'b1;
        tick();
        check("overflow_cleared", 64'(bus.overflow), 64'd0);

        // End of download with two entries queued
        prog_rdy = 1'b0;
        wr_byte(22'h08_0010, 8'hB1, 1'b1, 21'h00_0008, 2'd1, 2'b10);
        wr_byte(22'h08_0011, 8'hB2, 1'b1, 21'h00_0008, 2'd1, 2'b01);
        downloading = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_while_queued", 64'(bus.dwnld_busy), 64'd1);
            check("no_early_done", 64'(bus.dwnld_done), 64'd0);
        end
        prog_rdy = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dwnld_done) begin
                done_cnt++;
                check("busy_low_at_done", 64'(bus.dwnld_busy), 64'd0);
                check("we_low_at_done", 64'(bus.prog_we), 64'd0);
            end
        end
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("done_queue_empty", 64'(sb_q.size()), 64'd0);

        // PROM region
        downloading = 1'b1;
        tick();
`ifdef JTFRAME_DWNLD_PROM_EN
        wr_byte(22'h20_0005, 8'hC3, 1'b0, 21'd0, 2'd0, 2'b00);
        check("prom_we", 64'(bus.prom_we), 64'd1);
        check("prom_addr", 64'(bus.prom_addr), 64'd5);
        check("prom_no_prog_we", 64'(bus.prog_we), 64'd0);
        tick();
        check("prom_we_pulse", 64'(bus.prom_we), 64'd0);
`else
        wr_byte(22'h20_0005, 8'hC3, 1'b1, 21'h04_0002, 2'd3, 2'b01);
        check("prom_tied", 64'(bus.prom_we), 64'd0);
        drain();
`endif

        // Reset mid-transfer with three entries queued
        prog_rdy = 1'b0;
        wr_byte(22'h00_0300, 8'hD0, 1'b0, 21'd0, 2'd0, 2'b00);
        wr_byte(22'h00_0301, 8'hD1, 1'b0, 21'd0, 2'd0, 2'b00);
        wr_byte(22'h00_0302, 8'hD2, 1'b0, 21'd0, 2'd0, 2'b00);
        check("pre_rst_we", 64'(bus.prog_we), 64'd1);
        rst = 1'b1;
        downloading = 1'b0;
        tick();
        check("midrst_we", 64'(bus.prog_we), 64'd0);
        check("midrst_busy", 64'(bus.dwnld_busy), 64'd0);
        check("midrst_mask", 64'(bus.prog_mask), 64'(2'b11));
        rst = 1'b0;
        prog_rdy = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dwnld_done) done_cnt++;
            check("post_rst_we", 64'(bus.prog_we), 64'd0);
        end
        check("post_rst_no_done", 64'(done_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jtframe_prog_dwnld.md
JTFRAME_PROG_DWNLD -- requirements
Module: jtframe_prog_dwnld

Interface
REQ-001 Parameter AW, 22, byte address width of the download stream.
REQ-002 Parameter BA1_START, 22'h08_0000, first byte address mapped to SDRAM bank 1.
REQ-003 Parameter BA2_START, 22'h10_0000, first byte address mapped to bank 2.
REQ-004 Parameter BA3_START, 22'h18_0000, first byte address mapped to bank 3.
REQ-005 Parameter PROM_START, 22'h20_0000, first byte address of the PROM region; used only with JTFRAME_DWNLD_PROM_EN.
REQ-006 Parameter SWAB, 0, 1 swaps the byte lanes within each 16-bit word.
REQ-007 Parameter FIFO_AW, 2, log2 of write-FIFO depth; depth 4 by default.
REQ-008 The module SHALL have the ports below; reset is synchronous and active-high on one clock, clk.
REQ-009 clk  in  1  system clock; all logic on its rising edge.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 downloading  in  1  high while the ROM download is in progress.
REQ-012 ioctl_addr  in  AW  byte address of the incoming byte.
REQ-013 ioctl_data  in  8  incoming byte.
REQ-014 ioctl_wr  in  1  one-cycle strobe; the byte is valid on this cycle.
REQ-015 prog_addr  out  AW-1  SDRAM word address, relative to the start of its bank.
REQ-016 prog_ba  out  2  SDRAM bank.
REQ-017 prog_data  out  16  byte replicated on both lanes, {b,b}.
REQ-018 prog_mask  out  2  active-low lane mask: 2'b10 writes the low lane, 2'b01 writes the high lane.
REQ-019 prog_we  out  1  write request; held high until acknowledged.
REQ-020 prog_rdy  in  1  SDRAM acknowledge; consumes the current entry on the cycle it is high with prog_we.
REQ-021 prom_we  out  1  one-cycle PROM write strobe.
REQ-022 prom_addr  out  AW  PROM-relative byte address.
REQ-023 dwnld_busy  out  1  high while downloading is high or the FIFO is not empty.
REQ-024 dwnld_done  out  1  one-cycle pulse when the download completes.
REQ-025 overflow  out  1  sticky flag: a byte was lost because the FIFO was full.

Function
REQ-026 Bank select SHALL use the highest region whose start is <= ioctl_addr: bank 0 below BA1_START, then banks 1, 2 and 3.
REQ-027 Relative byte address SHALL be ioctl_addr minus the start of its bank; prog_addr = relative>>1.
REQ-028 Lane select: with SWAB=0, relative[0]=0 SHALL give mask 2'b10 and relative[0]=1 SHALL give mask 2'b01; SWAB=1 SHALL invert the selection.
REQ-029 On ioctl_wr, the module SHALL push the entry {addr, ba, byte, mask} into the FIFO on the same edge.
REQ-030 prog_we SHALL assert no earlier than the cycle after the push (latency 1 when the FIFO was empty).
REQ-031 prog_addr, prog_ba, prog_data and prog_mask SHALL stay stable while prog_we is high and prog_rdy is low.
REQ-032 When prog_we and prog_rdy are both high, the module SHALL pop the entry; if another entry is queued, it SHALL present it on the next cycle with prog_we still high.
REQ-033 A push and a pop in the same cycle SHALL both occur and leave the count unchanged.
REQ-034 Overflow handling:
- ioctl_wr while the FIFO is full (and no pop in that cycle) SHALL drop the byte and set overflow.
- overflow SHALL clear only on rst or on a rising edge of downloading.
REQ-035 ioctl_wr while downloading is low SHALL be ignored.
REQ-036 dwnld_done SHALL pulse for one cycle on the first cycle where downloading is low, the FIFO is empty, no write is pending, and busy was high on the previous cycle.
REQ-037 Address pointers SHALL wrap modulo 2^FIFO_AW.

Reset
REQ-038 On rst, the module SHALL empty the FIFO and hold these outputs at 0 on the next edge: prog_we, prom_we, dwnld_done, overflow, dwnld_busy, prog_addr, prog_ba, prog_data, prog_mask=2'b11.
REQ-039 rst mid-transfer SHALL abandon pending entries with no further prog_we.

Configuration
REQ-040 Macro JTFRAME_DWNLD_PROM_EN:
- Defined: bytes with ioctl_addr >= PROM_START SHALL bypass the FIFO and produce prom_we one cycle after ioctl_wr, with prom_addr = ioctl_addr - PROM_START.
- Undefined: prom_we SHALL be tied to 0 and prom_addr to 0, and all bytes SHALL go to the SDRAM path using REQ-026.

Verification
REQ-041 Bytes 0x11 and 0x22 written to addr 0 and 1, prog_rdy tied high -> two writes: addr 0, ba 0, data 16'h1111, mask 2'b10; then addr 0, ba 0, data 16'h2222, mask 2'b01.
REQ-042 Write to addr 22'h10_0003 -> ba 2, prog_addr 1, mask 2'b01; with SWAB=1 -> mask 2'b10.
REQ-043 prog_rdy held low, 5 writes with FIFO_AW=2 -> 4 entries held, overflow=1, prog_we stable; release prog_rdy -> 4 writes in 4 consecutive cycles, in order.
REQ-044 downloading falls with 2 entries queued -> dwnld_busy stays 1 until the last pop, then dwnld_done pulses exactly one cycle.
REQ-045 With JTFRAME_DWNLD_PROM_EN, write to addr 22'h20_0005 -> prom_we one cycle later, prom_addr 5, no prog_we; without the macro -> prog_we to ba 3.
REQ-046 rst asserted with 3 entries queued -> on the next edge, prog_we=0 and FIFO empty; no dwnld_done pulse.
